// File: rtl/cascade_pkg.sv
// Shared definitions for the detection-window position generator: coordinate
// widths, last-position arithmetic and the scan FSM state type.
package cascade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // Never returns 0 so a degenerate 1-pixel extent still yields a legal vector.
    function automatic int coord_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    function automatic int last_pos(input int img, input int win, input int step);
        return ((img - win) / step) * step;
    endfunction

endpackage

// File: rtl/window_pos_gen_stride_counter.sv
// Coordinate counter: clears to 0, advances by STEP, wraps to 0 after LAST.
// Exposes the next value so the owner can register flags about the new position.
module stride_counter #(
    parameter int W    = 6,
    parameter int LAST = 21,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    output logic [W-1:0] value,
    output logic [W-1:0] value_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST_V = W'(LAST);
    localparam logic [W-1:0] STEP_V = W'(STEP);

    logic [W-1:0] sum;

    // The add is only used when value < LAST, and LAST is a multiple of STEP,
    // so the sum never exceeds LAST and cannot overflow W bits.
    assign sum  = value + STEP_V;
    assign wrap = (value == LAST_V);

    always_comb begin
        value_next = value;
        if (clear)
            value_next = '0;
        else if (advance)
            value_next = wrap ? '0 : sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else
            value <= value_next;
    end

endmodule

// File: rtl/window_pos_gen.sv
// Raster-scan generator of detection-window top-left positions for one frame
// per accepted start; the last position of the frame carries eot.
//
// state    | meaning
// ST_IDLE  | waiting for start; start_ready high
// ST_SCAN  | presenting positions on the valid/ready stream
// ST_DRAIN | eot position accepted; frame_done pulses for this one cycle
module window_pos_gen
    import cascade_pkg::*;
#(
    parameter  int IMG_WIDTH  = 45,
    parameter  int IMG_HEIGHT = 45,
    parameter  int WIN_WIDTH  = 24,
    parameter  int WIN_HEIGHT = 24,
    parameter  int STEP_X     = 1,
    parameter  int STEP_Y     = 1,
    localparam int W_X        = coord_width(IMG_WIDTH),
    localparam int W_Y        = coord_width(IMG_HEIGHT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_valid,
    output logic           start_ready,
    output logic           window_pos_valid,
    input  logic           window_pos_ready,
    output logic           window_pos_eot,
    output logic [W_X-1:0] window_pos_x,
    output logic [W_Y-1:0] window_pos_y,
    output logic           busy,
    output logic           frame_done
);

    localparam int X_LAST = last_pos(IMG_WIDTH, WIN_WIDTH, STEP_X);
    localparam int Y_LAST = last_pos(IMG_HEIGHT, WIN_HEIGHT, STEP_Y);
    localparam logic [W_X-1:0] X_LAST_V = W_X'(X_LAST);
    localparam logic [W_Y-1:0] Y_LAST_V = W_Y'(Y_LAST);

    scan_state_t    state, state_next;
    logic           valid_next, eot_next;
    logic           clear, handshake, at_final, adv_x, adv_y;
    logic           x_wrap, y_wrap;
    logic [W_X-1:0] x_next;
    logic [W_Y-1:0] y_next;

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_DRAIN);

    assign handshake = window_pos_valid && window_pos_ready;
    assign at_final  = x_wrap && y_wrap;
    assign clear     = start_valid && (state == ST_IDLE);
    assign adv_x     = (state == ST_SCAN) && handshake && !at_final;
    assign adv_y     = adv_x && x_wrap;

    stride_counter #(.W(W_X), .LAST(X_LAST), .STEP(STEP_X)) u_x_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (adv_x),
        .value      (window_pos_x),
        .value_next (x_next),
        .wrap       (x_wrap)
    );

    stride_counter #(.W(W_Y), .LAST(Y_LAST), .STEP(STEP_Y)) u_y_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .advance    (adv_y),
        .value      (window_pos_y),
        .value_next (y_next),
        .wrap       (y_wrap)
    );

    // eot is registered alongside the position it describes, so it is
    // derived from the counters' next values rather than their current ones.
    always_comb begin
        state_next = state;
        valid_next = window_pos_valid;
        eot_next   = window_pos_eot;
        case (state)
            ST_IDLE: begin
                if (start_valid) begin
                    state_next = ST_SCAN;
                    valid_next = 1'b1;
                    eot_next   = (x_next == X_LAST_V) && (y_next == Y_LAST_V);
                end
            end
            ST_SCAN: begin
                if (handshake) begin
                    if (at_final) begin
                        state_next = ST_DRAIN;
                        valid_next = 1'b0;
                        eot_next   = 1'b0;
                    end else begin
                        eot_next = (x_next == X_LAST_V) && (y_next == Y_LAST_V);
                    end
                end
            end
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            window_pos_valid <= 1'b0;
            window_pos_eot   <= 1'b0;
        end else begin
            state            <= state_next;
            window_pos_valid <= valid_next;
            window_pos_eot   <= eot_next;
        end
    end

endmodule

// File: tb/tb_window_pos_gen.sv
// Bench for window_pos_gen: three parameterisations share one stimulus path,
// each frame compared against a raster list built from the geometry.
module tb_window_pos_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_valid = 1'b0;
    logic ready = 1'b0;
    int   sel = 0;

    logic       st[3];
    logic       sr[3];
    logic       pv[3];
    logic       pe[3];
    logic       bz[3];
    logic       fd[3];
    logic [5:0] px[3];
    logic [5:0] py[3];

    int ww[3] = '{24, 24, 45};
    int sx[3] = '{1, 4, 1};
    int sy[3] = '{1, 4, 1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign st[0] = start_valid && (sel == 0);
    assign st[1] = start_valid && (sel == 1);
    assign st[2] = start_valid && (sel == 2);

    window_pos_gen u_def (
        .clk(clk), .rst_n(rst_n), .start_valid(st[0]), .start_ready(sr[0]),
        .window_pos_valid(pv[0]), .window_pos_ready(ready), .window_pos_eot(pe[0]),
        .window_pos_x(px[0]), .window_pos_y(py[0]), .busy(bz[0]), .frame_done(fd[0])
    );

    window_pos_gen #(.STEP_X(4), .STEP_Y(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start_valid(st[1]), .start_ready(sr[1]),
        .window_pos_valid(pv[1]), .window_pos_ready(ready), .window_pos_eot(pe[1]),
        .window_pos_x(px[1]), .window_pos_y(py[1]), .busy(bz[1]), .frame_done(fd[1])
    );

    window_pos_gen #(.WIN_WIDTH(45), .WIN_HEIGHT(45)) u_one (
        .clk(clk), .rst_n(rst_n), .start_valid(st[2]), .start_ready(sr[2]),
        .window_pos_valid(pv[2]), .window_pos_ready(ready), .window_pos_eot(pe[2]),
        .window_pos_x(px[2]), .window_pos_y(py[2]), .busy(bz[2]), .frame_done(fd[2])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one frame on DUT k starting from IDLE at a falling edge. stall_pct
    // is the chance per cycle of holding ready low; hold keeps start_valid
    // asserted throughout; stop_idx >= 0 returns while that position is shown.
    task automatic scan(input int k, input int stall_pct, input bit hold, input int stop_idx);
        int qx[$];
        int qy[$];
        int xl, yl, n, idx, cyc;
        bit hs;
        xl = ((45 - ww[k]) / sx[k]) * sx[k];
        yl = ((45 - ww[k]) / sy[k]) * sy[k];
        for (int yy = 0; yy <= yl; yy += sy[k])
            for (int xx = 0; xx <= xl; xx += sx[k]) begin
                qx.push_back(xx);
                qy.push_back(yy);
            end
        n = qx.size();

        chk("idle_start_ready", 32'(sr[k]), 1);
        chk("idle_valid", 32'(pv[k]), 0);
        chk("idle_busy", 32'(bz[k]), 0);
        start_valid = 1'b1;
        ready = ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        if (!hold) start_valid = 1'b0;

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < n * 20 + 50) begin
            chk("pos_valid", 32'(pv[k]), 1);
            chk("pos_x", 32'(px[k]), qx[idx]);
            chk("pos_y", 32'(py[k]), qy[idx]);
            chk("pos_eot", 32'(pe[k]), (idx == n - 1) ? 1 : 0);
            chk("scan_busy", 32'(bz[k]), 1);
            chk("scan_start_ready", 32'(sr[k]), 0);
            chk("scan_frame_done", 32'(fd[k]), 0);
            if (stop_idx >= 0 && idx == stop_idx) begin
                ready = 1'b0;
                return;
            end
            hs = ready;
            @(negedge clk);
            if (hs) idx++;
            cyc++;
            ready = ($urandom_range(99) >= stall_pct);
        end
        chk("frame_count", idx, n);

        chk("drain_frame_done", 32'(fd[k]), 1);
        chk("drain_valid", 32'(pv[k]), 0);
        chk("drain_eot", 32'(pe[k]), 0);
        chk("drain_busy", 32'(bz[k]), 1);
        chk("drain_start_ready", 32'(sr[k]), 0);
        @(negedge clk);
        chk("after_frame_done", 32'(fd[k]), 0);
        chk("after_busy", 32'(bz[k]), 0);
        chk("after_start_ready", 32'(sr[k]), 1);
        chk("after_valid", 32'(pv[k]), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pv[0]), 0);
        chk("rst_eot", 32'(pe[0]), 0);
        chk("rst_x", 32'(px[0]), 0);
        chk("rst_y", 32'(py[0]), 0);
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_frame_done", 32'(fd[0]), 0);
        chk("rst_start_ready", 32'(sr[0]), 1);
        rst_n = 1'b1;
        @(negedge clk);

        scan(0, 0, 1'b0, -1);
        scan(0, 40, 1'b0, -1);
        // start held across a whole frame, then a new frame begins from the held request
        scan(0, 0, 1'b1, -1);
        scan(0, 0, 1'b0, 3 * 22 + 7);

        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(pv[0]), 0);
        chk("async_rst_busy", 32'(bz[0]), 0);
        chk("async_rst_frame_done", 32'(fd[0]), 0);
        @(negedge clk);
        chk("in_rst_frame_done", 32'(fd[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_frame_done", 32'(fd[0]), 0);
        scan(0, 0, 1'b0, -1);

        sel = 1;
        scan(1, 0, 1'b0, -1);
        scan(1, 30, 1'b0, -1);

        sel = 2;
        scan(2, 0, 1'b0, -1);
        scan(2, 50, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
